// File: rtl/apb_reg_slave.sv
// APB register slave: ID, CTRL, sticky W1C STATUS with irq, cycle COUNT and a scratch bank.
// Define APB_REG_SLAVE_SLVERR_EN to answer unmapped accesses and ID writes with s_pslverr.
module apb_reg_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE    = 32'hC0DE_0001,
  parameter int          NUM_SCRATCH = 4,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_paddr,
  input  logic        s_pwrite,
  input  logic [31:0] s_pwdata,
  input  logic        s_psel,
  input  logic        s_penable,
  output logic        s_pready,
  output logic [31:0] s_prdata,
  output logic        s_pslverr,
  output logic [31:0] ctrl_out,
  input  logic [31:0] status_in,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_reg;
  logic [3:0]  wait_reg;
  logic [29:0] addr_reg;
  logic        write_reg;
  logic [31:0] wdata_reg;
  logic [31:0] ctrl_reg;
  logic [31:0] status_reg;
  logic [31:0] count_reg;
  logic [31:0] scratch_reg [NUM_SCRATCH];

  logic                   in_range;
  logic [29:0]            word;
  logic                   fire;
  logic                   wr_fire;
  logic                   sel_id;
  logic                   sel_ctrl;
  logic                   sel_status;
  logic                   sel_count;
  logic [NUM_SCRATCH-1:0] sel_scratch;
  logic [31:0]            rdata_next;
  logic                   err_next;
  logic                   unused_addr_lsb;

  // Byte lane bits of the address carry no information for word registers.
  assign unused_addr_lsb = &{1'b0, s_paddr[1:0]};

  assign in_range   = (addr_reg >= BASE_ADDR[31:2]);
  assign word       = addr_reg - BASE_ADDR[31:2];
  assign sel_id     = in_range && (word == 30'd0);
  assign sel_ctrl   = in_range && (word == 30'd1);
  assign sel_status = in_range && (word == 30'd2);
  assign sel_count  = in_range && (word == 30'd3);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch_sel
      assign sel_scratch[gi] = in_range && (word == 30'(gi + 4));
    end
  endgenerate

  assign fire    = (state_reg == ACCESS) && s_psel && s_penable && (wait_reg == 4'd0);
  assign wr_fire = fire && write_reg;

  always_comb begin
    rdata_next = '0;
    if (sel_id)     rdata_next = ID_VALUE;
    if (sel_ctrl)   rdata_next = ctrl_reg;
    if (sel_status) rdata_next = status_reg;
    if (sel_count)  rdata_next = count_reg;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (sel_scratch[i]) rdata_next = scratch_reg[i];
    end
  end

`ifdef APB_REG_SLAVE_SLVERR_EN
  assign err_next = !(sel_id || sel_ctrl || sel_status || sel_count || (|sel_scratch))
                    || (sel_id && write_reg);
`else
  assign err_next = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wait_reg  <= '0;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
      s_pready  <= 1'b0;
      s_prdata  <= '0;
      s_pslverr <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (s_psel && !s_penable) begin
            addr_reg  <= s_paddr[31:2];
            write_reg <= s_pwrite;
            wdata_reg <= s_pwdata;
            wait_reg  <= 4'(WAIT_CYCLES);
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          if (!s_psel) begin
            state_reg <= IDLE;
          end else if (s_penable) begin
            if (wait_reg == 4'd0) begin
              s_pready  <= 1'b1;
              s_prdata  <= write_reg ? 32'd0 : rdata_next;
              s_pslverr <= err_next;
              state_reg <= RESP;
            end else begin
              wait_reg <= wait_reg - 4'd1;
            end
          end
        end
        RESP: begin
          s_pready  <= 1'b0;
          s_prdata  <= '0;
          s_pslverr <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Status set has priority over a same-cycle write-one-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg   <= '0;
      status_reg <= '0;
      count_reg  <= '0;
      irq        <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_reg[i] <= '0;
    end else begin
      if (wr_fire && sel_ctrl) ctrl_reg <= wdata_reg;
      status_reg <= (status_reg & ~((wr_fire && sel_status) ? wdata_reg : 32'd0)) | status_in;
      count_reg  <= (wr_fire && sel_count) ? 32'd0 : count_reg + 32'd1;
      irq        <= |status_reg;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (wr_fire && sel_scratch[i]) scratch_reg[i] <= wdata_reg;
      end
    end
  end

  assign ctrl_out = ctrl_reg;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Randomized bench for apb_reg_slave against a transaction-level register model.
module tb_apb_reg_slave;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] IDV  = 32'hC0DE_0001;
  localparam int          NS   = 4;
  localparam int          W    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [31:0] ctrl_out;
  logic [31:0] status_in;
  logic        irq;

  always #5 clk = ~clk;

  apb_reg_slave #(
    .BASE_ADDR(BASE), .ID_VALUE(IDV), .NUM_SCRATCH(NS), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_paddr(paddr), .s_pwrite(pwrite), .s_pwdata(pwdata),
    .s_psel(psel), .s_penable(penable), .s_pready(pready), .s_prdata(prdata),
    .s_pslverr(pslverr), .ctrl_out(ctrl_out), .status_in(status_in), .irq(irq)
  );

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  // Rising edges since reset release; COUNT equals edge_n minus the edge of the last clear.
  always @(posedge clk) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  logic [31:0] ctrl_m;
  logic [31:0] status_m;
  logic [31:0] scratch_m [NS];
  int          base_m;
  logic        last_irq_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // 0 ID, 1 CTRL, 2 STATUS, 3 COUNT, 4 SCRATCH, 5 unmapped
  function automatic int decode(input logic [31:0] addr, output int idx);
    logic [31:0] off;
    idx = 0;
    if (addr < BASE) return 5;
    off = (addr & ~32'd3) - BASE;
    if (off == 32'h0) return 0;
    if (off == 32'h4) return 1;
    if (off == 32'h8) return 2;
    if (off == 32'hC) return 3;
    if (off >= 32'h10 && off < 32'h10 + 32'(4 * NS)) begin
      idx = int'((off - 32'h10) >> 2);
      return 4;
    end
    return 5;
  endfunction

  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output logic irq_rdy,
                          output int alen, output int done_edge);
    int n;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (pready) break;
    end
    if (!pready) chk("pready_timeout", 32'd0, 32'd1);
    alen = n + 1;
    rd = prdata; err = pslverr; irq_rdy = irq; done_edge = edge_n;
    @(negedge clk);
    chk("pready_pulse", 32'(pready), 32'd0);
    chk("prdata_clr", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wd);
    int          kind, idx, alen, done;
    logic [31:0] rd, exp_rd;
    logic        err, irq_rdy, exp_err;
    kind = decode(addr, idx);
    status_m = status_m | status_in;
    case (kind)
      0: exp_rd = IDV;
      1: exp_rd = ctrl_m;
      2: exp_rd = status_m;
      4: exp_rd = scratch_m[idx];
      default: exp_rd = 32'd0;
    endcase
    apb_xfer(addr, wr, wd, rd, err, irq_rdy, alen, done);
    last_irq_rdy = irq_rdy;
    if (kind == 3) exp_rd = 32'(done - 1 - base_m);
`ifdef APB_REG_SLAVE_SLVERR_EN
    exp_err = (kind == 5) || (kind == 0 && wr);
`else
    exp_err = 1'b0;
`endif
    if (!wr) chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_slverr"}, 32'(err), 32'(exp_err));
    chk({tag, "_alen"}, 32'(alen), 32'(W + 2));
    if (wr) begin
      case (kind)
        1: ctrl_m = wd;
        2: status_m = (status_m & ~wd) | status_in;
        3: base_m = done;
        4: scratch_m[idx] = wd;
        default: ;
      endcase
    end
    chk({tag, "_ctrl_out"}, ctrl_out, ctrl_m);
    chk({tag, "_irq"}, 32'(irq), 32'(status_m != 32'd0));
    $display("xfer %s %s addr=%h wdata=%h rdata=%h err=%b alen=%0d", tag, wr ? "WR" : "RD",
             addr, wd, rd, err, alen);
  endtask

  task automatic model_reset();
    ctrl_m = '0; status_m = '0; base_m = 0;
    for (int i = 0; i < NS; i++) scratch_m[i] = '0;
  endtask

  initial begin
    int          sel;
    logic [31:0] a;
    psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0; status_in = '0;
    last_irq_rdy = 1'b0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_ctrl", ctrl_out, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;

    do_op("id", BASE, 1'b0, 32'd0);
    do_op("ctrl_wr", BASE + 32'h4, 1'b1, 32'hA5A5_5A5A);
    do_op("ctrl_rd", BASE + 32'h4, 1'b0, 32'd0);

    @(negedge clk); status_in = 32'h10;
    @(negedge clk); status_in = 32'h0;
    status_m = status_m | 32'h10;
    do_op("st_rd", BASE + 32'h8, 1'b0, 32'd0);
    status_in = 32'h10;
    do_op("st_setwins", BASE + 32'h8, 1'b1, 32'h10);
    status_in = 32'h0;
    do_op("st_rd2", BASE + 32'h8, 1'b0, 32'd0);
    do_op("st_clr", BASE + 32'h8, 1'b1, 32'h10);
    chk("irq_lag", 32'(last_irq_rdy), 32'd1);
    do_op("st_rd3", BASE + 32'h8, 1'b0, 32'd0);

    repeat (7) @(negedge clk);
    do_op("cnt_rd0", BASE + 32'hC, 1'b0, 32'd0);
    do_op("cnt_clr", BASE + 32'hC, 1'b1, 32'h1234_5678);
    do_op("cnt_rd1", BASE + 32'hC, 1'b0, 32'd0);
    do_op("cnt_rd2", BASE + 32'hC, 1'b0, 32'd0);

    @(negedge clk);
    force dut.count_reg = 32'hFFFF_FFFE;
    #1 release dut.count_reg;
    @(negedge clk); chk("cnt_max", dut.count_reg, 32'hFFFF_FFFF);
    @(negedge clk); chk("cnt_wrap", dut.count_reg, 32'd0);
    do_op("cnt_resync", BASE + 32'hC, 1'b1, 32'd0);

    do_op("unmap_rd", BASE + 32'h10 + 32'(4 * NS), 1'b0, 32'd0);
    do_op("id_wr", BASE, 1'b1, 32'hFFFF_FFFF);
    do_op("below_rd", BASE - 32'h4, 1'b0, 32'd0);
    do_op("unmap_wr", BASE + 32'h80, 1'b1, 32'h5555_5555);
    do_op("id_rd2", BASE, 1'b0, 32'd0);
    do_op("ctrl_rd2", BASE + 32'h4, 1'b0, 32'd0);

    for (int k = 0; k < 60; k++) begin
      sel = int'($urandom_range(0, 10));
      if (sel < 4)       a = BASE + 32'(4 * sel);
      else if (sel < 8)  a = BASE + 32'h10 + 32'(4 * (sel - 4));
      else if (sel == 8) a = BASE + 32'h10 + 32'(4 * NS);
      else if (sel == 9) a = BASE + 32'h80;
      else               a = BASE - 32'h8;
      a = a | ($urandom & 32'h3);
      status_in = $urandom & $urandom & $urandom & $urandom;
      do_op("rnd", a, 1'($urandom_range(0, 1)), $urandom);
    end
    status_in = 32'h0;

    do_op("scr0_pre", BASE + 32'h10, 1'b1, 32'h0F0F_1234);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = BASE + 32'h10; pwrite = 1'b1; pwdata = 32'hDEAD_BEEF;
    @(negedge clk); penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_pready", 32'(pready), 32'd0);
    chk("midrst_ctrl", ctrl_out, 32'd0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op("scr0_after_rst", BASE + 32'h10, 1'b0, 32'd0);
    do_op("cnt_after_rst", BASE + 32'hC, 1'b0, 32'd0);
    do_op("scr0_wr", BASE + 32'h10, 1'b1, 32'h1357_9BDF);
    do_op("scr0_rd", BASE + 32'h10, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
